// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port front end for the 32-bit data RAM.
// Sub-word stores are read-modify-write; DMEM_ALIGN_CHECK_EN adds misalignment errors.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0_VALID,
    output logic                  REQ0_READY,
    input  logic                  REQ0_WE,
    input  logic [1:0]            REQ0_SIZE,
    input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
    input  logic                  REQ1_VALID,
    output logic                  REQ1_READY,
    input  logic                  REQ1_WE,
    input  logic [1:0]            REQ1_SIZE,
    input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
    output logic                  RSP0_VALID,
    output logic [DATA_WIDTH-1:0] RSP0_RDATA,
    output logic                  RSP0_ERR,
    output logic                  RSP1_VALID,
    output logic [DATA_WIDTH-1:0] RSP1_RDATA,
    output logic                  RSP1_ERR,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_A,
    output logic [DATA_WIDTH-1:0] MEM_WD,
    input  logic [DATA_WIDTH-1:0] MEM_RD
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;

    state_t                  state, state_next;
    logic                    last;
    logic                    grant0, grant1;
    logic                    hs, hs_id;
    logic                    cap_we, cap_id;
    logic [1:0]              cap_size;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [DATA_WIDTH-1:0]   old_data;
    logic                    misaligned, done, rsp_err;
    logic [DATA_WIDTH-1:0]   load_data, merge_data, rsp_data;

    // last = 1 means requester 1 was granted most recently
    assign grant0 = REQ0_VALID && (!REQ1_VALID || last);
    assign grant1 = REQ1_VALID && (!REQ0_VALID || !last);
    assign hs     = REQ0_READY || REQ1_READY;
    assign hs_id  = REQ1_READY;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (cap_size == 2'b01 && cap_addr[0]) ||
                        (cap_size[1] && cap_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        load_data = MEM_RD;
        if (cap_size == 2'b00)
            load_data = {{(DATA_WIDTH-8){1'b0}}, MEM_RD[7:0]};
        else if (cap_size == 2'b01)
            load_data = {{(DATA_WIDTH-16){1'b0}}, MEM_RD[15:0]};
    end

    assign merge_data = cap_size[0] ?
        {old_data[DATA_WIDTH-1:16], cap_wdata[15:0]} :
        {old_data[DATA_WIDTH-1:8], cap_wdata[7:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        MEM_WE     = 1'b0;
        MEM_A      = '0;
        MEM_WD     = '0;
        done       = 1'b0;
        rsp_data   = '0;
        rsp_err    = 1'b0;
        unique case (state)
            IDLE: begin
                REQ0_READY = grant0 && !RST;
                REQ1_READY = grant1 && !RST;
                if (grant0 || grant1) state_next = ACCESS;
            end
            ACCESS: begin
                MEM_A = cap_addr;
                done  = 1'b1;
                if (misaligned) begin
                    rsp_err = 1'b1;
                end else if (!cap_we) begin
                    rsp_data = load_data;
                end else if (cap_size[1]) begin
                    MEM_WE = 1'b1;
                    MEM_WD = cap_wdata;
                end else begin
                    done       = 1'b0;
                    state_next = MERGE;
                end
                if (done) state_next = IDLE;
            end
            MERGE: begin
                MEM_WE     = 1'b1;
                MEM_A      = cap_addr;
                MEM_WD     = merge_data;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last       <= 1'b1;
            cap_we     <= 1'b0;
            cap_id     <= 1'b0;
            cap_size   <= 2'b00;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            old_data   <= '0;
            RSP0_VALID <= 1'b0;
            RSP0_RDATA <= '0;
            RSP0_ERR   <= 1'b0;
            RSP1_VALID <= 1'b0;
            RSP1_RDATA <= '0;
            RSP1_ERR   <= 1'b0;
        end else begin
            RSP0_VALID <= done && !cap_id;
            RSP1_VALID <= done && cap_id;
            if (hs) begin
                last      <= hs_id;
                cap_id    <= hs_id;
                cap_we    <= hs_id ? REQ1_WE    : REQ0_WE;
                cap_size  <= hs_id ? REQ1_SIZE  : REQ0_SIZE;
                cap_addr  <= hs_id ? REQ1_ADDR  : REQ0_ADDR;
                cap_wdata <= hs_id ? REQ1_WDATA : REQ0_WDATA;
            end
            if (state == ACCESS) old_data <= MEM_RD;
            if (done && !cap_id) begin
                RSP0_RDATA <= rsp_data;
                RSP0_ERR   <= rsp_err;
            end
            if (done && cap_id) begin
                RSP1_RDATA <= rsp_data;
                RSP1_ERR   <= rsp_err;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random requests against a byte-level
// reference memory; a behavioural RAM sits on the MEM_* port.
module tb_dmem_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ0_VALID, REQ0_READY, REQ0_WE;
    logic [1:0]  REQ0_SIZE;
    logic [9:0]  REQ0_ADDR;
    logic [31:0] REQ0_WDATA;
    logic        REQ1_VALID, REQ1_READY, REQ1_WE;
    logic [1:0]  REQ1_SIZE;
    logic [9:0]  REQ1_ADDR;
    logic [31:0] REQ1_WDATA;
    logic        RSP0_VALID, RSP0_ERR, RSP1_VALID, RSP1_ERR;
    logic [31:0] RSP0_RDATA, RSP1_RDATA;
    logic        MEM_WE;
    logic [9:0]  MEM_A;
    logic [31:0] MEM_WD, MEM_RD;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] ram     [1024];
    logic [7:0] ref_mem [1024];

    dmem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
        .REQ0_WE(REQ0_WE), .REQ0_SIZE(REQ0_SIZE),
        .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
        .REQ1_WE(REQ1_WE), .REQ1_SIZE(REQ1_SIZE),
        .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
        .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA), .RSP0_ERR(RSP0_ERR),
        .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA), .RSP1_ERR(RSP1_ERR),
        .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
    );

    always #5 CLK = ~CLK;

    // RAM: combinational read, whole-word write, addresses wrap
    assign MEM_RD = {ram[MEM_A + 10'd3], ram[MEM_A + 10'd2],
                     ram[MEM_A + 10'd1], ram[MEM_A]};
    always @(posedge CLK) begin
        if (MEM_WE) begin
            ram[MEM_A]         = MEM_WD[7:0];
            ram[MEM_A + 10'd1] = MEM_WD[15:8];
            ram[MEM_A + 10'd2] = MEM_WD[23:16];
            ram[MEM_A + 10'd3] = MEM_WD[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_mis(input logic [1:0] size, input logic [9:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
        return (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [9:0] addr, input logic [1:0] size);
        logic [31:0] r = '0;
        for (int k = 0; k < nbytes(size); k++)
            r[8*k +: 8] = ref_mem[addr + 10'(k)];
        return r;
    endfunction

    task automatic drive(input int id, input logic v, input logic we,
                         input logic [1:0] size, input logic [9:0] addr,
                         input logic [31:0] wdata);
        if (id == 0) begin
            REQ0_VALID = v; REQ0_WE = we; REQ0_SIZE = size;
            REQ0_ADDR = addr; REQ0_WDATA = wdata;
        end else begin
            REQ1_VALID = v; REQ1_WE = we; REQ1_SIZE = size;
            REQ1_ADDR = addr; REQ1_WDATA = wdata;
        end
    endtask

    task automatic do_req(input int id, input logic we, input logic [1:0] size,
                          input logic [9:0] addr, input logic [31:0] wdata);
        int c, lat, we_cyc, n;
        logic seen, mis, v_own, v_oth;
        logic [31:0] exp_d, rd;
        @(negedge CLK);
        drive(id, 1'b1, we, size, addr, wdata);
        #1;
        c = 0;
        seen = (id == 0) ? REQ0_READY : REQ1_READY;
        while (!seen && c < 20) begin
            @(negedge CLK); #1; c++;
            seen = (id == 0) ? REQ0_READY : REQ1_READY;
        end
        check("ready", {31'b0, seen}, 32'd1);
        if (!seen) begin
            drive(id, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
            return;
        end
        n = nbytes(size);
        mis = is_mis(size, addr);
        exp_d = (mis || we) ? 32'd0 : ref_load(addr, size);
        lat = (!mis && we && n < 4) ? 3 : 2;
        we_cyc = (mis || !we) ? 0 : (n < 4 ? 2 : 1);
        if (we && !mis)
            for (int k = 0; k < n; k++)
                ref_mem[addr + 10'(k)] = wdata[8*k +: 8];
        for (int k = 1; k <= lat; k++) begin
            @(negedge CLK);
            if (k == 1) drive(id, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
            #1;
            check("mem_we", {31'b0, MEM_WE}, {31'b0, k == we_cyc});
            if (k == we_cyc) check("mem_a", {22'b0, MEM_A}, {22'b0, addr});
            v_own = (id == 0) ? RSP0_VALID : RSP1_VALID;
            v_oth = (id == 0) ? RSP1_VALID : RSP0_VALID;
            check("rsp_valid", {31'b0, v_own}, {31'b0, k == lat});
            check("rsp_other", {31'b0, v_oth}, 32'd0);
            if (k == lat) begin
                rd = (id == 0) ? RSP0_RDATA : RSP1_RDATA;
                check("rsp_rdata", rd, exp_d);
                check("rsp_err", {31'b0, (id == 0) ? RSP0_ERR : RSP1_ERR}, {31'b0, mis});
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {30'b0, REQ1_READY, REQ0_READY}, 32'd0);
        check({tag, "_rspv"}, {30'b0, RSP1_VALID, RSP0_VALID}, 32'd0);
        check({tag, "_rd0"}, RSP0_RDATA, 32'd0);
        check({tag, "_rd1"}, RSP1_RDATA, 32'd0);
        check({tag, "_err"}, {30'b0, RSP1_ERR, RSP0_ERR}, 32'd0);
        check({tag, "_mem"}, {MEM_WE, MEM_A, 21'b0}, 32'd0);
        check({tag, "_wd"}, MEM_WD, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, exp_w, exp_c0, exp_c1, nbad, id;
        logic [31:0] ed0, ed1;
        logic [1:0] sz;
        logic [9:0] a;

        for (int i = 0; i < 1024; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        RST = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        repeat (2) @(negedge CLK);
        #1 check_idle_outputs("reset");
        @(negedge CLK);
        RST = 1'b0;
        #1 check_idle_outputs("post_reset");

        // word store then load
        do_req(0, 1'b1, 2'b10, 10'h010, 32'hDEADBEEF);
        do_req(0, 1'b0, 2'b10, 10'h010, 32'd0);
        // byte RMW from requester 1
        do_req(0, 1'b1, 2'b10, 10'h020, 32'h11223344);
        do_req(1, 1'b1, 2'b00, 10'h021, 32'h000000AA);
        do_req(0, 1'b0, 2'b10, 10'h020, 32'd0);
        do_req(1, 1'b1, 2'b01, 10'h022, 32'h0000BEEF);
        do_req(1, 1'b0, 2'b10, 10'h020, 32'd0);
        // wrap at top of memory
        do_req(0, 1'b1, 2'b10, 10'h3FF, 32'hCAFEF00D);
        do_req(0, 1'b0, 2'b01, 10'h3FF, 32'd0);
        do_req(1, 1'b0, 2'b10, 10'h000, 32'd0);
        // misaligned word store
        do_req(0, 1'b1, 2'b10, 10'h006, 32'h12345678);
        do_req(0, 1'b0, 2'b10, 10'h004, 32'd0);

        // reset during MERGE of a byte store
        @(negedge CLK);
        drive(1, 1'b1, 1'b1, 2'b00, 10'h0A1, 32'h00000055);
        #1 check("rst_ready", {31'b0, REQ1_READY}, 32'd1);
        @(negedge CLK);
        drive(1, 1'b0, 1'b0, 2'b00, 10'd0, 32'd0);
        #1 check("rst_access_we", {31'b0, MEM_WE}, 32'd0);
        @(negedge CLK);
        #1 check("rst_merge_we", {31'b0, MEM_WE}, 32'd1);
        RST = 1'b1;
        #1 check("rst_async_we", {31'b0, MEM_WE}, 32'd0);
        @(negedge CLK);
        #1 check_idle_outputs("rst_mid");
        @(negedge CLK);
        RST = 1'b0;

        // both requesters hold VALID: grants alternate starting with 0
        drive(0, 1'b1, 1'b0, 2'b10, 10'h040, 32'd0);
        drive(1, 1'b1, 1'b0, 2'b01, 10'h082, 32'd0);
        hs = 0; exp_w = 0; exp_c0 = -1; exp_c1 = -1;
        ed0 = '0; ed1 = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (hs == 8) begin
                REQ0_VALID = 1'b0;
                REQ1_VALID = 1'b0;
            end
            #1;
            check("arb_rsp0_v", {31'b0, RSP0_VALID}, {31'b0, cyc == exp_c0});
            check("arb_rsp1_v", {31'b0, RSP1_VALID}, {31'b0, cyc == exp_c1});
            if (cyc == exp_c0) check("arb_rsp0_d", RSP0_RDATA, ed0);
            if (cyc == exp_c1) check("arb_rsp1_d", RSP1_RDATA, ed1);
            if (REQ0_READY || REQ1_READY) begin
                check("arb_grant", {30'b0, REQ1_READY, REQ0_READY},
                      (exp_w == 0) ? 32'd1 : 32'd2);
                if (exp_w == 0) begin
                    exp_c0 = cyc + 2; ed0 = ref_load(10'h040, 2'b10);
                end else begin
                    exp_c1 = cyc + 2; ed1 = ref_load(10'h082, 2'b01);
                end
                exp_w = 1 - exp_w;
                hs++;
            end
            @(negedge CLK);
        end
        check("arb_handshakes", hs, 32'd8);

        // the aborted byte store must not have touched memory
        do_req(0, 1'b0, 2'b10, 10'h0A0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            id = $urandom_range(0, 1);
            sz = 2'($urandom_range(0, 3));
            a  = 10'h3F8 + 10'($urandom_range(0, 15));
            do_req(id, 1'($urandom_range(0, 1)), sz, a, $urandom);
        end

        nbad = 0;
        for (int i = 0; i < 1024; i++)
            if (ram[i] !== ref_mem[i]) nbad++;
        check("mem_final", nbad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller in front of the byte-addressable 32-bit data RAM.
  - Requester 0: core load/store unit.
  - Requester 1: debug/DMA port.
- Arbitrates between the requesters with round-robin, sequences each access and returns a registered response.
- The RAM only performs full 32-bit writes at bytes A..A+3. Byte and halfword stores are therefore done as read-modify-write.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 for the size/merge logic.
- ADDR_WIDTH, 10, byte-address width; equals $clog2(MEM_DEPTH) of the RAM (1024).

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQn_VALID  input  1  request valid; n = 0,1 for every REQn/RSPn signal.
- REQn_READY  output  1  request accepted on the cycle where VALID&&READY.
- REQn_WE  input  1  1 = store, 0 = load.
- REQn_SIZE  input  2  00 byte, 01 half, 10/11 word.
- REQn_ADDR  input  ADDR_WIDTH  byte address.
- REQn_WDATA  input  DATA_WIDTH  store data, right-justified.
- RSPn_VALID  output  1  one-cycle completion pulse, for loads and stores.
- RSPn_RDATA  output  DATA_WIDTH  load data, zero-extended; 0 for stores.
- RSPn_ERR  output  1  alignment error flag; tied 0 unless DMEM_ALIGN_CHECK_EN.
- MEM_WE  output  1  RAM write enable.
- MEM_A  output  ADDR_WIDTH  RAM address.
- MEM_WD  output  DATA_WIDTH  RAM write data.
- MEM_RD  input  DATA_WIDTH  RAM read data (combinational, {A+3,A+2,A+1,A}).

Behaviour:
- Reset (async, RST=1): all outputs 0, FSM=IDLE, round-robin pointer = "last granted 1" (so requester 0 wins first), captured request cleared.
  - Reset mid-operation drops the pending operation: no RSP, no MEM_WE.
- FSM states: IDLE, ACCESS, MERGE.
- IDLE:
  - REQn_READY=1 only for the arbitration winner; 0 for the other requester and in all other states.
  - Handshake captures WE, SIZE, ADDR, WDATA and requester ID, then go to ACCESS.
  - No VALID: stay in IDLE.
- Arbitration:
  - Only one VALID: that requester wins.
  - Both VALID: winner is the requester not granted last.
  - Pointer updates on every handshake.
- ACCESS (MEM_A = captured ADDR):
  - Load: register MEM_RD masked by SIZE (byte -> [7:0], half -> [15:0], word -> all), zero-extended. Return to IDLE.
  - Word store: MEM_WE=1, MEM_WD=WDATA. Return to IDLE.
  - Byte/half store: register MEM_RD as old data, MEM_WE=0, go to MERGE.
- MERGE:
  - MEM_WE=1, MEM_A = captured ADDR.
  - MEM_WD = {old[31:8], WDATA[7:0]} for byte; {old[31:16], WDATA[15:0]} for half.
  - Return to IDLE.
- Response:
  - RSPn_VALID pulses for exactly one cycle, on the cycle after the final ACCESS/MERGE cycle, to the captured requester only.
  - RSPn_RDATA is held until the next response to that requester.
  - A new handshake may occur in the same cycle as the RSP pulse.
- Latency from handshake cycle T: load and word store RSP at T+2; byte/half store RSP at T+3; throughput one request per 2 or 3 cycles.
- MEM_WE is 1 only in ACCESS for a word store or in MERGE; 0 otherwise, including in IDLE.
- Address wrap: ADDR is passed through unmodified; the RAM wraps A+k modulo 2^ADDR_WIDTH (word at 1023 touches 1023,0,1,2).
- Requester inputs are don't-care while READY=0. A requester must hold VALID and its fields stable until the handshake.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - Half with ADDR[0]!=0, or word with ADDR[1:0]!=0, is misaligned.
  - In ACCESS: no MEM_WE, no MERGE, return to IDLE.
  - RSP at T+2 with RSPn_ERR=1 and RSPn_RDATA=0.
  - Aligned accesses: ERR=0.
- Undefined: RSPn_ERR is constant 0 and misaligned accesses proceed unchanged (unaligned byte span).

Test Plan:
- Reset, then REQ0 word store A=0x010 WD=0xDEADBEEF, then load word A=0x010 -> MEM_WE pulse at T+1; load RSP0_RDATA=0xDEADBEEF at its T+2.
- Word 0x11223344 at 0x020, then REQ1 byte store A=0x021 WD=0xAA -> MERGE writes 0x1122AA44 at A=0x021 bytes; word load at 0x020 returns 0x1122AA44; store RSP1 at T+3.
- REQ0 and REQ1 VALID held continuously, loads -> grants alternate 0,1,0,1 from reset; no requester starved; each RSP goes to the correct port.
- Half load A=0x3FF after word 0xCAFEF00D at 0x3FF -> RSP0_RDATA=0x0000F00D; a word store at 0x3FF writes bytes 0x3FF,0x000,0x001,0x002.
- Assert RST during MERGE of a byte store -> MEM_WE=0 immediately, no RSP; memory word unchanged; next request serviced normally with requester 0 first.
- With DMEM_ALIGN_CHECK_EN: word store A=0x006 -> no MEM_WE, RSP0_ERR=1 at T+2. Without the macro: write occurs, ERR=0.
